// File: rtl/event_encoder.sv
`default_nettype none
// ============================================================================
// event_encoder
//   Timestamps pixel-arbiter grants and group-end markers into a show-ahead
//   packet FIFO with drop accounting.
//   Revision 1.0
// ============================================================================
module event_encoder #(
  parameter  int Lvl_ADD    = 1,
  parameter  int TS_W       = 16,
  parameter  int FIFO_DEPTH = 8,
  localparam int PKT_W      = 1 + 2*Lvl_ADD + TS_W,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               active_i,
  input  logic               gnt_valid_i,
  input  logic [Lvl_ADD-1:0] x_add_i,
  input  logic [Lvl_ADD-1:0] y_add_i,
  input  logic               grp_release_i,
  output logic [PKT_W-1:0]   pkt_o,
  output logic               pkt_valid_o,
  input  logic               pkt_ready_i,
  output logic               overflow_o,
  output logic [7:0]         drop_cnt_o,
  input  logic               clr_i,
  output logic [LVL_W-1:0]   fifo_level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [TS_W-1:0]    ts;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [LVL_W-1:0]   level;
  logic [PKT_W-1:0]   mem [FIFO_DEPTH];
  logic               rel_q;
  logic               marker_pending;
  logic               pend_nxt;
  logic               active_q_unused;
  logic               overflow;
  logic [7:0]         drop_cnt;

  logic               full;
  logic               empty;
  logic               pop;
  logic               rel_edge;
  logic               ev_wr;
  logic               ev_drop;
  logic               mk_wr;
  logic               wr_en;
  logic [PKT_W-1:0]   wr_data;

  assign full     = (level == LVL_W'(FIFO_DEPTH));
  assign empty    = (level == '0);
  assign pop      = !empty && pkt_ready_i;
  assign rel_edge = grp_release_i && !rel_q;
  assign wr_en    = ev_wr || mk_wr;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Full is judged on the pre-pop level, so a same-cycle pop never frees a slot.
  always_comb begin
    state_nxt = state;
    ev_wr     = 1'b0;
    ev_drop   = 1'b0;
    mk_wr     = 1'b0;
    wr_data   = '0;
    pend_nxt  = marker_pending;
    case (state)
      IDLE: begin
        pend_nxt = 1'b0;
        if (enable_i) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!enable_i) begin
          state_nxt = IDLE;
        end
        if (gnt_valid_i) begin
          ev_wr   = !full;
          ev_drop = full;
          wr_data = {1'b0, x_add_i, y_add_i, ts};
        end else if (marker_pending && !full) begin
          mk_wr   = 1'b1;
          wr_data = {1'b1, {(2*Lvl_ADD){1'b0}}, ts};
        end
        // Release edges arriving while a marker is still owed merge into it.
        pend_nxt = marker_pending ? !mk_wr : rel_edge;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      ts              <= '0;
      rel_q           <= 1'b0;
      marker_pending  <= 1'b0;
      active_q_unused <= 1'b0;
    end else begin
      ts              <= (state == RUN) ? ts + TS_W'(1) : '0;
      rel_q           <= grp_release_i;
      marker_pending  <= pend_nxt;
      active_q_unused <= active_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_en && !pop) begin
        level <= level + LVL_W'(1);
      end else if (!wr_en && pop) begin
        level <= level - LVL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // A clear in the same cycle as a drop takes priority.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_i) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (ev_drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign pkt_o        = empty ? '0 : mem[rd_ptr];
  assign pkt_valid_o  = !empty;
  assign overflow_o   = overflow;
  assign drop_cnt_o   = drop_cnt;
  assign fifo_level_o = level;

endmodule
`default_nettype wire

// File: tb/tb_event_encoder.sv
`default_nettype none
// Bench for event_encoder: vector table, directed corner sequences and a
// randomized run compared against a queue-based packet model.
module tb_event_encoder;

  localparam int PW    = 19;
  localparam int WPW   = 7;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_i;
  logic           enable, active, gnt, x, y, rel, ready, clr;
  logic [PW-1:0]  pkt;
  logic           valid, ovf;
  logic [7:0]     dcnt;
  logic [3:0]     lvl;

  logic           w_en, w_gnt, w_x, w_y, w_ready;
  logic [WPW-1:0] w_pkt;
  logic           w_valid, w_ovf;
  logic [7:0]     w_dcnt;
  logic [3:0]     w_lvl;

  event_encoder dut (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable), .active_i(active),
    .gnt_valid_i(gnt), .x_add_i(x), .y_add_i(y), .grp_release_i(rel),
    .pkt_o(pkt), .pkt_valid_o(valid), .pkt_ready_i(ready),
    .overflow_o(ovf), .drop_cnt_o(dcnt), .clr_i(clr), .fifo_level_o(lvl)
  );

  event_encoder #(.TS_W(4)) dut_w (
    .clk_i(clk), .reset_i(reset_i), .enable_i(w_en), .active_i(1'b0),
    .gnt_valid_i(w_gnt), .x_add_i(w_x), .y_add_i(w_y), .grp_release_i(1'b0),
    .pkt_o(w_pkt), .pkt_valid_o(w_valid), .pkt_ready_i(w_ready),
    .overflow_o(w_ovf), .drop_cnt_o(w_dcnt), .clr_i(1'b0), .fifo_level_o(w_lvl)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: packet queue plus the few scalars the rules mention.
  logic [PW-1:0] mq[$];
  bit  m_run, m_pend, m_relq, m_ovf;
  int  m_ts, m_drop;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    check("model_valid", valid, (mq.size() != 0));
    check("model_level", lvl, mq.size());
    check("model_pkt", pkt, (mq.size() != 0) ? mq[0] : '0);
    check("model_overflow", ovf, m_ovf);
    check("model_drop_cnt", dcnt, m_drop);
  endtask

  task automatic tick();
    bit full_s, pop_s, push_s, drop_s, mk_s, rise_s, en_s, n_pend, n_ovf;
    int n_ts, n_drop;
    logic [PW-1:0] p;
    full_s = (mq.size() == DEPTH);
    pop_s  = (mq.size() != 0) && ready;
    push_s = 1'b0; drop_s = 1'b0; mk_s = 1'b0; p = '0;
    en_s   = enable;
    n_pend = 1'b0; n_ts = 0;
    if (m_run) begin
      rise_s = rel && !m_relq;
      if (gnt) begin
        if (full_s) drop_s = 1'b1;
        else begin
          push_s = 1'b1;
          p = {1'b0, x, y, m_ts[15:0]};
        end
      end else if (m_pend && !full_s) begin
        push_s = 1'b1;
        mk_s   = 1'b1;
        p = {1'b1, 2'b00, m_ts[15:0]};
      end
      n_pend = m_pend ? !mk_s : rise_s;
      n_ts   = (m_ts + 1) % 65536;
    end
    n_ovf = m_ovf; n_drop = m_drop;
    if (clr) begin
      n_ovf = 1'b0; n_drop = 0;
    end else if (drop_s) begin
      n_ovf = 1'b1; n_drop = (m_drop < 255) ? m_drop + 1 : 255;
    end
    m_relq = rel;
    @(posedge clk);
    #1;
    if (pop_s) void'(mq.pop_front());
    if (push_s) mq.push_back(p);
    m_run = en_s; m_pend = n_pend; m_ts = n_ts; m_ovf = n_ovf; m_drop = n_drop;
    compare_model();
  endtask

  task automatic idle_inputs();
    enable = 0; active = 0; gnt = 0; x = 0; y = 0; rel = 0; ready = 0; clr = 0;
    w_en = 0; w_gnt = 0; w_x = 0; w_y = 0; w_ready = 0;
  endtask

  // Asserts reset between edges to check the asynchronous clear.
  task automatic do_reset();
    idle_inputs();
    #2;
    reset_i = 1'b0;
    #1;
    check("reset_valid", valid, 0);
    check("reset_level", lvl, 0);
    check("reset_pkt", pkt, 0);
    check("reset_ovf_drop", {ovf, dcnt}, 0);
    check("reset_w_valid", w_valid, 0);
    @(posedge clk);
    #1;
    reset_i = 1'b1;
    mq.delete();
    m_run = 0; m_pend = 0; m_relq = 0; m_ovf = 0; m_ts = 0; m_drop = 0;
  endtask

  typedef struct {
    logic en, g, xa, ya, r, rdy, c;
    logic exp_valid;
    int   exp_lvl;
    logic [PW-1:0] exp_pkt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ready_pct;
    logic prev_valid, prev_ready;
    logic [PW-1:0] prev_pkt;

    reset_i = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    do_reset();

    // en, gnt, x, y, rel, ready, clr | valid, level, head packet
    tbl[0]  = '{1,0,0,0,0,0,0, 0,0,19'h00000};
    tbl[1]  = '{1,1,1,0,0,0,0, 1,1,19'h20000};
    tbl[2]  = '{1,1,0,1,1,0,0, 1,2,19'h20000};
    tbl[3]  = '{1,0,0,0,1,0,0, 1,3,19'h20000};
    tbl[4]  = '{1,0,0,0,0,1,0, 1,2,19'h10001};
    tbl[5]  = '{1,0,0,0,0,1,0, 1,1,19'h40002};
    tbl[6]  = '{1,0,0,0,0,1,0, 0,0,19'h00000};
    tbl[7]  = '{0,0,0,0,0,0,1, 0,0,19'h00000};
    tbl[8]  = '{0,1,1,1,1,0,0, 0,0,19'h00000};
    tbl[9]  = '{1,0,0,0,0,0,0, 0,0,19'h00000};
    tbl[10] = '{1,1,1,1,0,0,0, 1,1,19'h30000};
    tbl[11] = '{1,0,0,0,0,1,0, 0,0,19'h00000};
    for (int i = 0; i < 12; i++) begin
      enable = tbl[i].en; gnt = tbl[i].g; x = tbl[i].xa; y = tbl[i].ya;
      rel = tbl[i].r; ready = tbl[i].rdy; clr = tbl[i].c;
      tick();
      check($sformatf("vec%0d_valid", i), valid, tbl[i].exp_valid);
      check($sformatf("vec%0d_level", i), lvl, tbl[i].exp_lvl);
      check($sformatf("vec%0d_pkt", i), pkt, tbl[i].exp_pkt);
    end

    // Single event; a grant on the enabling edge itself is ignored.
    do_reset();
    enable = 1; gnt = 1; x = 1; y = 0;
    tick();
    check("first_edge_ignored", lvl, 0);
    gnt = 0;
    tick();
    tick();
    gnt = 1;
    check("single_pre_valid", valid, 0);
    tick();
    gnt = 0;
    check("single_valid", valid, 1);
    check("single_pkt", pkt, 19'h20002);

    // Overflow, clear, full-with-pop rejection, clear-beats-drop, saturation.
    do_reset();
    enable = 1;
    tick();
    gnt = 1;
    repeat (10) begin
      x = 1'($urandom_range(0, 1)); y = 1'($urandom_range(0, 1));
      tick();
    end
    check("ovf_level", lvl, 8);
    check("ovf_drop_cnt", dcnt, 2);
    check("ovf_flag", ovf, 1);
    gnt = 0; clr = 1;
    tick();
    clr = 0;
    check("clr_drop_cnt", dcnt, 0);
    check("clr_flag", ovf, 0);
    check("clr_level_kept", lvl, 8);
    gnt = 1; ready = 1;
    tick();
    check("full_pop_reject_level", lvl, 7);
    check("full_pop_reject_drop", dcnt, 1);
    ready = 0;
    tick();
    check("refill_level", lvl, 8);
    clr = 1;
    tick();
    clr = 0;
    check("clr_wins_drop", dcnt, 0);
    check("clr_wins_flag", ovf, 0);
    repeat (260) tick();
    check("drop_saturate", dcnt, 255);
    gnt = 0; rel = 1;
    tick();
    tick();
    check("marker_wait_full", lvl, 8);
    ready = 1;
    tick();
    check("marker_not_on_pop", lvl, 7);
    ready = 0;
    tick();
    check("marker_written", lvl, 8);
    ready = 1;
    repeat (7) tick();
    check("marker_last_level", lvl, 1);
    check("marker_last_type", pkt[18], 1);
    rel = 0;
    tick();
    check("marker_drained", valid, 0);

    // Reset with entries queued and a marker owed.
    do_reset();
    enable = 1;
    tick();
    gnt = 1;
    repeat (4) tick();
    rel = 1;
    tick();
    check("pre_reset_level", lvl, 5);
    do_reset();
    enable = 1;
    repeat (3) tick();
    check("no_marker_after_reset", lvl, 0);
    enable = 0;
    tick();
    gnt = 1;
    repeat (3) tick();
    check("disabled_ignored", lvl, 0);
    gnt = 0;

    // Timestamp wrap on the 4-bit instance.
    do_reset();
    w_en = 1; w_x = 1; w_y = 1;
    tick();
    for (int k = 0; k < 20; k++) begin
      w_gnt = (k == 15 || k == 16);
      tick();
    end
    w_gnt = 0;
    check("wrap_level", w_lvl, 2);
    check("wrap_pkt_ts15", w_pkt, 7'h3F);
    w_ready = 1;
    tick();
    check("wrap_pkt_ts0", w_pkt, 7'h30);
    tick();
    check("wrap_drained", w_valid, 0);

    // Randomized traffic with varying backpressure.
    do_reset();
    ready_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) ready_pct = (c / 200 % 3 == 0) ? 15 : (c / 200 % 3 == 1) ? 50 : 90;
      enable = ($urandom_range(0, 31) != 0);
      active = 1'($urandom_range(0, 1));
      gnt    = 1'($urandom_range(0, 1));
      x      = 1'($urandom_range(0, 1));
      y      = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) rel = ~rel;
      ready  = ($urandom_range(0, 99) < ready_pct);
      clr    = ($urandom_range(0, 63) == 0);
      prev_valid = valid; prev_ready = ready; prev_pkt = pkt;
      tick();
      if (prev_valid && !prev_ready) check("stall_hold", pkt, prev_pkt);
    end

    idle_inputs();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/event_encoder.md
EVENT_ENCODER -- requirements
Module: event_encoder

Interface
REQ-001 SHALL have parameters, one per line:
- Lvl_ADD, 1, width of each address field.
- TS_W, 16, timestamp width.
- FIFO_DEPTH, 8, packet FIFO entries; power of two, at least 2.
REQ-002 SHALL have ports, one per line:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous active-low reset.
- enable_i  in  1  same enable that drives the pixel arbiter level.
- active_i  in  1  arbiter active indication.
- gnt_valid_i  in  1  one-cycle pulse, a pixel grant was issued this cycle.
- x_add_i  in  Lvl_ADD  granted row index.
- y_add_i  in  Lvl_ADD  granted column index.
- grp_release_i  in  1  arbiter group-release.
- pkt_o  out  PKT_W  FIFO head packet, PKT_W = 1+2*Lvl_ADD+TS_W.
- pkt_valid_o  out  1  head packet valid.
- pkt_ready_i  in  1  consumer ready.
- overflow_o  out  1  sticky drop flag.
- drop_cnt_o  out  8  saturating dropped-event count.
- clr_i  in  1  synchronous clear of overflow_o and drop_cnt_o.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  occupancy.
REQ-003 SHALL use this packet layout, MSB first: type, x, y, ts. Type 0 = pixel event, 1 = group-end marker. A marker carries x=0 and y=0.

Function
REQ-004 SHALL run a two-state FSM, IDLE and RUN. IDLE->RUN when enable_i=1. RUN->IDLE when enable_i=0; this takes effect on the next clock edge.
REQ-005 In IDLE:
- ts counter is held at 0.
- gnt_valid_i and grp_release_i are ignored.
- marker_pending is cleared.
- FIFO continues to drain.
REQ-006 In RUN, ts increments by 1 per clock and wraps from 2^TS_W-1 to 0 with no other effect.
REQ-007 When gnt_valid_i=1 in RUN cycle N, SHALL write {0,x_add_i,y_add_i,ts(N)} at edge N+1 if the FIFO is not full.
REQ-008 SHALL detect the rising edge of grp_release_i in RUN, using a registered copy of grp_release_i, and set marker_pending.
REQ-009 While marker_pending=1 and no event write occurs in the cycle, SHALL write {1,0,0,ts} if the FIFO is not full, then clear marker_pending.
REQ-010 Simultaneous event and marker: the event is written first; the marker stays pending and is written in the next cycle with no event write.
REQ-011 A new release edge while marker_pending=1 SHALL NOT create a second marker (edges merge).
REQ-012 Full is evaluated before the same-cycle pop. A write when full is rejected even if pkt_ready_i=1 in that cycle.
REQ-013 A rejected event SHALL be dropped:
- overflow_o is set.
- drop_cnt_o increments and saturates at 255.
REQ-014 A marker is never dropped; it stays pending until space exists.
REQ-015 pkt_valid_o=1 exactly when the FIFO is non-empty. pkt_o presents the head combinationally from FIFO storage (show-ahead).
REQ-016 A pop occurs when pkt_valid_o and pkt_ready_i are both 1. pkt_o and pkt_valid_o SHALL hold stable while pkt_valid_o=1 and pkt_ready_i=0.
REQ-017 Latency: an event written into an empty FIFO appears on pkt_o with pkt_valid_o=1 in cycle N+1.
REQ-018 Read and write pointers wrap modulo FIFO_DEPTH. fifo_level_o = writes minus pops and ranges 0..FIFO_DEPTH.
REQ-019 clr_i=1 clears overflow_o and drop_cnt_o at the next edge. If a drop occurs in the same cycle, the clear wins.
REQ-020 active_i is informational only: it is registered for debug and does not gate writes.

Reset
REQ-021 reset_i=0 SHALL asynchronously force:
- state to IDLE.
- ts, pointers and marker_pending to 0.
- pkt_valid_o, overflow_o, drop_cnt_o and fifo_level_o to 0.
- pkt_o to 0.
REQ-022 After reset_i is released, the first write is possible no earlier than the second rising clk_i edge; one edge is needed to enter RUN.
REQ-023 Reset asserted mid-operation SHALL discard all FIFO contents and any pending marker.

Verification
REQ-024 Single event:
- Stimulus: enable at cycle 0, gnt_valid_i pulse at cycle 3 with x=1, y=0, TS_W=16, Lvl_ADD=1.
- Response: pkt_o = {0,1,0,ts} with the ts sampled at cycle 3; pkt_valid_o rises one cycle later.
REQ-025 Simultaneous event and release:
- Stimulus: event (x=0,y=1) and grp_release_i rising edge in the same cycle.
- Response: event packet first, marker {1,0,0,ts+1} in the next entry.
REQ-026 Overflow:
- Stimulus: pkt_ready_i=0 and 10 events with FIFO_DEPTH=8.
- Response: fifo_level_o=8, drop_cnt_o=2, overflow_o=1; a pulse on clr_i returns both to 0.
REQ-027 Backpressure hold:
- Stimulus: toggle pkt_ready_i randomly.
- Response: pkt_o stays stable while stalled; packet order is preserved with no duplicates.
REQ-028 Reset and disable mid-stream:
- Stimulus: drive reset_i low with 5 entries queued.
- Response: pkt_valid_o=0 immediately.
- Stimulus: enable_i=0.
- Response: ts=0 and gnt_valid_i is ignored.
REQ-029 Timestamp wrap:
- Stimulus: TS_W=4, run 20 cycles, events at cycles 15 and 16.
- Response: ts values 15 and 0.
